// File: rtl/fpu_pkg.sv
// Shared types for the FPU request/response front end: opcodes, word width,
// default core latency and the result-buffer entry layout.
package fpu_pkg;

    localparam int FPU_WORD_W      = 32;
    localparam int FPU_LAT_DEFAULT = 3;
    localparam int FPU_TAG_W       = 4;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } fpu_op_t;

    typedef struct packed {
        logic [FPU_WORD_W-1:0] result;
        fpu_op_t               op;
        logic [FPU_TAG_W-1:0]  tag;
    } rsp_entry_t;

endpackage

// File: rtl/fpu_req_responder_if.sv
// Request and response channels between an initiator and the FPU front end.
// Both channels: a transfer happens on a posedge where valid && ready; the
// producer may change or drop its payload freely when no transfer occurred.
interface fpu_req_responder_if
    import fpu_pkg::*;
#(
    parameter int TAG_W = 4
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [FPU_WORD_W-1:0] req_a;
    logic [FPU_WORD_W-1:0] req_b;
    fpu_op_t               req_op;
    logic [TAG_W-1:0]      req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [FPU_WORD_W-1:0] rsp_result;
    fpu_op_t               rsp_op;
    logic [TAG_W-1:0]      rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_op, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_op, rsp_tag
    );

endinterface

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO. When empty, the head output keeps showing the
// most recently popped entry so the response fields never go undefined.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  rsp_entry_t    pushData,
    input  logic          pop,
    output rsp_entry_t    headData,
    output logic [CW-1:0] count
);

    rsp_entry_t     mem [DEPTH];
    rsp_entry_t     lastPopped;
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic           doPush;
    logic           doPop;

    assign doPush = push && (count != CW'(DEPTH));
    assign doPop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            lastPopped <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr      <= rdPtr + PW'(1);
                lastPopped <= mem[rdPtr];
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign headData = (count != '0) ? mem[rdPtr] : lastPopped;

endmodule

// File: rtl/fpu_req_responder.sv
// Responder front end for the FPU core: registers operands onto the core,
// tracks in-flight ops in a shadow pipe and returns tagged results in order.
module fpu_req_responder
    import fpu_pkg::*;
#(
    parameter int FPU_LAT    = FPU_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = FPU_TAG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    fpu_req_responder_if.slave    bus,
    output logic [FPU_WORD_W-1:0] fpu_a,
    output logic [FPU_WORD_W-1:0] fpu_b,
    output fpu_op_t               fpu_op,
    input  logic [FPU_WORD_W-1:0] fpu_o,
    output logic                  busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic             accept;
    logic             capture;
    logic             popHead;
    logic [CW-1:0]    inflightCount;
    logic [CW-1:0]    fifoCount;
    logic [SW-1:0]    creditsUsed;
    rsp_entry_t       pushEntry;
    rsp_entry_t       headEntry;

    logic             stgValid [FPU_LAT];
    fpu_op_t          stgOp    [FPU_LAT];
    logic [TAG_W-1:0] stgTag   [FPU_LAT];

    assign accept  = bus.req_valid && bus.req_ready;
    assign capture = stgValid[FPU_LAT-1];
    assign popHead = bus.rsp_valid && bus.rsp_ready;

    // Credits cover both buffered and in-flight results, so every capture
    // has a FIFO slot reserved; req_ready depends on registered counts only.
    assign creditsUsed   = SW'(fifoCount) + SW'(inflightCount);
    assign bus.req_ready = creditsUsed < SW'(FIFO_DEPTH);
    assign busy          = (inflightCount != '0) || (fifoCount != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_op <= ADD;
        end else if (accept) begin
            fpu_a  <= bus.req_a;
            fpu_b  <= bus.req_b;
            fpu_op <= bus.req_op;
        end
    end

    // Shadow pipe mirrors the core's latency; the last stage marks the edge
    // on which fpu_o belongs to the op accepted FPU_LAT edges earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FPU_LAT; i++) begin
                stgValid[i] <= 1'b0;
                stgOp[i]    <= ADD;
                stgTag[i]   <= '0;
            end
        end else begin
            stgValid[0] <= accept;
            stgOp[0]    <= bus.req_op;
            stgTag[0]   <= bus.req_tag;
            for (int i = 1; i < FPU_LAT; i++) begin
                stgValid[i] <= stgValid[i-1];
                stgOp[i]    <= stgOp[i-1];
                stgTag[i]   <= stgTag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflightCount <= '0;
        end else begin
            case ({accept, capture})
                2'b10:   inflightCount <= inflightCount + CW'(1);
                2'b01:   inflightCount <= inflightCount - CW'(1);
                default: inflightCount <= inflightCount;
            endcase
        end
    end

    always_comb begin
        pushEntry        = '0;
        pushEntry.result = fpu_o;
        pushEntry.op     = stgOp[FPU_LAT-1];
        pushEntry.tag    = FPU_TAG_W'(stgTag[FPU_LAT-1]);
    end

    fpu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) resultFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .pushData (pushEntry),
        .pop      (popHead),
        .headData (headEntry),
        .count    (fifoCount)
    );

    assign bus.rsp_valid  = fifoCount != '0;
    assign bus.rsp_result = headEntry.result;
    assign bus.rsp_op     = headEntry.op;
    assign bus.rsp_tag    = TAG_W'(headEntry.tag);

endmodule

// File: tb/tb_fpu_req_responder.sv
// Directed bench for fpu_req_responder with a behavioural 3-cycle core model
// built from exactly representable floats.
module tb_fpu_req_responder;
    import fpu_pkg::*;

    localparam int TAG_W = 4;
    localparam int NUM_TESTS = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    fpu_op_t     fpu_op;
    logic [31:0] fpu_o;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int received = 0;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    fpu_req_responder_if #(.TAG_W(TAG_W)) bus ();

    fpu_req_responder #(
        .FPU_LAT    (3),
        .FIFO_DEPTH (4),
        .TAG_W      (TAG_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .fpu_a  (fpu_a),
        .fpu_b  (fpu_b),
        .fpu_op (fpu_op),
        .fpu_o  (fpu_o),
        .busy   (busy)
    );

    function automatic real sp_to_real(input logic [31:0] w);
        real m;
        int  e;
        if (w[30:0] == 31'd0) return 0.0;
        e = int'(w[30:23]) - 127;
        m = (1.0 + $itor(w[22:0]) / 8388608.0) * (2.0 ** $itor(e));
        return w[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] de;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        de = d[62:52] - 11'd896;
        return {d[63], de[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_to_sp(input int i);
        return real_to_sp($itor(i));
    endfunction

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input fpu_op_t op);
        real ra;
        real rb;
        ra = sp_to_real(a);
        rb = sp_to_real(b);
        case (op)
            ADD:     return real_to_sp(ra + rb);
            SUB:     return real_to_sp(ra - rb);
            MUL:     return real_to_sp(ra * rb);
            default: return (rb == 0.0) ? 32'd0 : real_to_sp(ra / rb);
        endcase
    endfunction

    // Core stand-in: result of the registered operands appears on fpu_o in
    // time to be sampled three posedges after the operands were loaded.
    logic [31:0] core1;
    logic [31:0] core2;
    always @(posedge clk) begin
        core1 <= core_fn(fpu_a, fpu_b, fpu_op);
        core2 <= core1;
    end
    assign fpu_o = core2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                             input fpu_op_t op, input logic [3:0] tag);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
    endtask

    task automatic push_exp(input fpu_op_t op, input logic [3:0] tag, input logic [31:0] res);
        exp_q.push_back({op, tag, res});
    endtask

    // Called at a negedge: the head shown now is popped on the next posedge.
    task automatic pop_if_valid(input string name);
        logic [37:0] e;
        if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL %s_extra: observed unexpected tag %0d expected none", name, bus.rsp_tag);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({name, "_result"}, bus.rsp_result, e[31:0]);
                check({name, "_tag"}, 32'(bus.rsp_tag), 32'(e[35:32]));
                check({name, "_op"}, 32'(bus.rsp_op), 32'(e[37:36]));
            end
            received++;
        end
    endtask

    task automatic drain(input string name, input int n, input int budget, input bit stall);
        received = 0;
        for (int cyc = 0; cyc < budget && received < n; cyc++) begin
            bus.rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pop_if_valid(name);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        check({name, "_count"}, 32'(received), 32'(n));
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        int sent;
        int ia;
        int ib;
        int res;
        bit holding;
        bit saw_valid;
        fpu_op_t rop;

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = ADD;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_fpu_op", 32'(fpu_op), 32'd0);

        // Single op: 1.0 + 2.0, tag 3
        drive_req(32'h3F800000, 32'h40000000, ADD, 4'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("single_fpu_a", fpu_a, 32'h3F800000);
        check("single_fpu_b", fpu_b, 32'h40000000);
        check("single_busy", 32'(busy), 32'd1);
        check("single_valid_k", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("single_valid_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_result", bus.rsp_result, 32'h40400000);
        check("single_op", 32'(bus.rsp_op), 32'(ADD));
        check("single_tag", 32'(bus.rsp_tag), 32'd3);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("single_valid_after_pop", 32'(bus.rsp_valid), 32'd0);
        check("single_busy_after_pop", 32'(busy), 32'd0);
        check("single_last_tag", 32'(bus.rsp_tag), 32'd3);
        check("single_last_result", bus.rsp_result, 32'h40400000);

        // Back-to-back: 3*2, 5-1.5, 6/2, 0.5+0.25
        push_exp(MUL, 4'd0, 32'h40C00000);
        push_exp(SUB, 4'd1, 32'h40600000);
        push_exp(DIV, 4'd2, 32'h40400000);
        push_exp(ADD, 4'd3, 32'h3F400000);
        bus.rsp_ready = 1'b1;
        check("b2b_ready0", 32'(bus.req_ready), 32'd1);
        drive_req(32'h40400000, 32'h40000000, MUL, 4'd0);
        @(negedge clk);
        check("b2b_ready1", 32'(bus.req_ready), 32'd1);
        drive_req(32'h40A00000, 32'h3FC00000, SUB, 4'd1);
        @(negedge clk);
        check("b2b_ready2", 32'(bus.req_ready), 32'd1);
        drive_req(32'h40C00000, 32'h40000000, DIV, 4'd2);
        @(negedge clk);
        check("b2b_ready3", 32'(bus.req_ready), 32'd1);
        drive_req(32'h3F000000, 32'h3E800000, ADD, 4'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain("b2b", 4, 30, 1'b0);

        // Backpressure / full: request held valid, consumer stalled
        accepts = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive_req(int_to_sp(accepts + 1), int_to_sp(1), ADD, 4'(4 + accepts));
            if (bus.req_ready) begin
                push_exp(ADD, 4'(4 + accepts), int_to_sp(accepts + 2));
                accepts++;
            end
            @(negedge clk);
        end
        check("full_accepts", 32'(accepts), 32'd4);
        check("full_req_ready", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        received = 0;
        pop_if_valid("full_pop");
        check("full_pop_seen", 32'(received), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("full_ready_after_pop", 32'(bus.req_ready), 32'd1);
        push_exp(ADD, 4'(4 + accepts), int_to_sp(accepts + 2));
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("full_ready_refilled", 32'(bus.req_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        drain("full", 4, 40, 1'b0);

        // Capture and pop on the same edge with two entries buffered
        push_exp(MUL, 4'd9, int_to_sp(9 * 3));
        push_exp(MUL, 4'd10, int_to_sp(10 * 3));
        push_exp(MUL, 4'd11, int_to_sp(11 * 3));
        drive_req(int_to_sp(9), int_to_sp(3), MUL, 4'd9);
        @(negedge clk);
        drive_req(int_to_sp(10), int_to_sp(3), MUL, 4'd10);
        @(negedge clk);
        drive_req(int_to_sp(11), int_to_sp(3), MUL, 4'd11);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("simul_count_before", 32'(dut.fifoCount), 32'd2);
        check("simul_head_before", 32'(bus.rsp_tag), 32'd9);
        bus.rsp_ready = 1'b1;
        pop_if_valid("simul_pop");
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("simul_count_after", 32'(dut.fifoCount), 32'd2);
        check("simul_head_after", 32'(bus.rsp_tag), 32'd10);
        check("simul_inflight", 32'(dut.inflightCount), 32'd0);
        drain("simul", 2, 20, 1'b0);

        // Reset with two ops in flight
        drive_req(int_to_sp(7), int_to_sp(2), ADD, 4'd12);
        @(negedge clk);
        drive_req(int_to_sp(8), int_to_sp(2), SUB, 4'd13);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_fpu_a", fpu_a, 32'd0);
        check("rstmid_fpu_b", fpu_b, 32'd0);
        check("rstmid_fpu_op", 32'(fpu_op), 32'd0);
        saw_valid = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.rsp_valid || busy) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("rstmid_no_response", 32'(saw_valid), 32'd0);

        // Random regression with consumer stalls
        sent = 0;
        holding = 1'b0;
        received = 0;
        for (int cyc = 0; cyc < 3000 && (sent < NUM_TESTS || exp_q.size() != 0); cyc++) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            pop_if_valid("rand");
            if (!holding) begin
                if (sent < NUM_TESTS && $urandom_range(0, 9) < 7) begin
                    rop = fpu_op_t'($urandom_range(0, 3));
                    if (rop == DIV) begin
                        ib = 1 << $urandom_range(0, 3);
                        ia = ib * int'($urandom_range(1, 16));
                    end else begin
                        ia = int'($urandom_range(1, 64));
                        ib = int'($urandom_range(1, 64));
                    end
                    case (rop)
                        ADD:     res = ia + ib;
                        SUB:     res = ia - ib;
                        MUL:     res = ia * ib;
                        default: res = ia / ib;
                    endcase
                    drive_req(int_to_sp(ia), int_to_sp(ib), rop, 4'(sent));
                    holding = 1'b1;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (holding && bus.req_ready) begin
                push_exp(rop, 4'(sent), int_to_sp(res));
                sent++;
                holding = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("rand_sent", 32'(sent), 32'(NUM_TESTS));
        check("rand_received", 32'(received), 32'(NUM_TESTS));
        check("rand_left", 32'(exp_q.size()), 32'd0);
        check("rand_busy_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
